// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the control FSM state encoding and the counter-width function.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/prod_reg_w.sv
// Product/carry register {carry, hi, lo} of the shift-add multiplier.
// Loads the multiplier into lo, or shifts {cin, sum, lo} right by one.
module prod_reg_w
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_ldp,
    input  logic             i_shp,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cin,
    output logic [2*WIDTH:0] o_p
);

    logic [2*WIDTH:0] r_p;

    // Load {0, 0, b} on start, otherwise add-shift while running
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_p <= '0;
        end else if (i_ldp) begin
            r_p <= {1'b0, {WIDTH{1'b0}}, i_b};
        end else if (i_shp) begin
            r_p <= {1'b0, i_cin, i_sum, r_p[WIDTH-1:1]};
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier with start/busy/done handshake.
// One add-shift per cycle for WIDTH cycles; product registered on DONE entry.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH:0]   w_p;
    logic [WIDTH:0]     w_sum;
    logic               w_ldp;
    logic               w_shp;
    logic               w_last;

    // Carry bit of P is always zero here, so {carry, hi} never overflows
    assign w_sum  = w_p[2*WIDTH:WIDTH] + (w_p[0] ? {1'b0, r_a} : '0);
    assign w_last = (r_cnt == CNT_W'(1));

    prod_reg_w #(
        .WIDTH(WIDTH)
    ) u_prod (
        .clk   (clk),
        .clr   (clr),
        .i_ldp (w_ldp),
        .i_shp (w_shp),
        .i_b   (b),
        .i_sum (w_sum[WIDTH-1:0]),
        .i_cin (w_sum[WIDTH]),
        .o_p   (w_p)
    );

    // Control state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and datapath strobes; start in DONE restarts directly
    always_comb begin
        w_next = r_state;
        w_ldp  = 1'b0;
        w_shp  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_ldp  = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_shp = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_ldp  = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Multiplicand captured on the accepting edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_a <= '0;
        end else if (w_ldp) begin
            r_a <= a;
        end
    end

    // Iteration counter: WIDTH add-shift cycles per operation
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (w_ldp) begin
            r_cnt <= CNT_W'(WIDTH);
        end else if (w_shp) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Output product takes the final shifted value on the last RUN edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_p <= '0;
        end else if (w_shp && w_last) begin
            r_p <= {w_sum, w_p[WIDTH-1:1]};
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign p    = r_p;

endmodule
